// File: rtl/iob_wishbone2iob_pkg.sv
// iob_wishbone2iob_pkg: state encoding shared by the bridge RTL and its bench.
// Revision: 1.0
`default_nettype none

package iob_wishbone2iob_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/iob_reg.sv
// iob_reg: register with async active-low reset, sync clear and enable.
// Revision: 1.0
`default_nettype none

module iob_reg #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  // Clear wins over enable so a capture can restart a register in one edge.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_o <= RST_VAL;
    end else if (rst_i) begin
      data_o <= RST_VAL;
    end else if (en_i) begin
      data_o <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/iob_wishbone2iob.sv
// iob_wishbone2iob: Wishbone classic slave to IOb master bridge, one IOb access per request.
// Optional watchdog: define IOB_WB2IOB_TIMEOUT_EN.  Revision: 1.0
`default_nettype none

module iob_wishbone2iob
  import iob_wishbone2iob_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W/8-1:0] wb_select_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic                wb_ack_o,
  output logic                wb_error_o,
  output logic                valid_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i
);

  localparam int STRB_W = DATA_W / 8;

  logic [STATE_W-1:0] state_q;
  state_t             state;
  state_t             state_nxt;
  logic               capture;
  logic               in_req;
  logic               abort_q;
  logic               abort_now;
  logic               timeout;
  logic               we_q;
  logic [STRB_W-1:0]  sel_q;

  assign state     = state_t'(state_q);
  assign in_req    = (state == REQ);
  // A cycle with cyc low counts as aborted even when it is the completing cycle.
  assign abort_now = abort_q | ~wb_cyc_i;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          capture   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (ready_i) begin
          state_nxt = abort_now ? IDLE : ACK;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  iob_reg #(.DATA_W(STATE_W), .RST_VAL(STATE_W'(IDLE))) state_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .rst_i(1'b0), .en_i(1'b1),
    .data_i(state_nxt), .data_o(state_q)
  );

  iob_reg #(.DATA_W(ADDR_W)) addr_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .rst_i(1'b0), .en_i(capture),
    .data_i(wb_addr_i), .data_o(address_o)
  );

  iob_reg #(.DATA_W(DATA_W)) wdata_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .rst_i(1'b0), .en_i(capture),
    .data_i(wb_data_i), .data_o(wdata_o)
  );

  iob_reg #(.DATA_W(STRB_W)) sel_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .rst_i(1'b0), .en_i(capture),
    .data_i(wb_select_i), .data_o(sel_q)
  );

  iob_reg #(.DATA_W(1)) we_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .rst_i(1'b0), .en_i(capture),
    .data_i(wb_we_i), .data_o(we_q)
  );

  iob_reg #(.DATA_W(1)) abort_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .rst_i(capture), .en_i(in_req & ~wb_cyc_i),
    .data_i(1'b1), .data_o(abort_q)
  );

  // Read data is kept even for aborted reads; writes never touch it.
  iob_reg #(.DATA_W(DATA_W)) rdata_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .rst_i(1'b0), .en_i(in_req & ready_i & ~we_q),
    .data_i(rdata_i), .data_o(wb_data_o)
  );

  assign valid_o  = in_req;
  assign wstrb_o  = we_q ? sel_q : '0;
  assign wb_ack_o = (state == ACK);

`ifdef IOB_WB2IOB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 error_nxt;

  iob_reg #(.DATA_W(TIMEOUT_W)) cnt_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .rst_i(capture), .en_i(in_req & ~ready_i),
    .data_i(cnt_q + 1'b1), .data_o(cnt_q)
  );

  assign timeout   = in_req & ~ready_i & (cnt_q == '1);
  assign error_nxt = timeout & ~abort_now;

  iob_reg #(.DATA_W(1)) error_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .rst_i(1'b0), .en_i(1'b1),
    .data_i(error_nxt), .data_o(wb_error_o)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_W > 0);
  assign timeout    = 1'b0;
  assign wb_error_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iob_wishbone2iob.sv
// tb_iob_wishbone2iob: directed and randomized checks of the Wishbone-to-IOb bridge
// against a transaction-level model. Revision: 1.0
`default_nettype none

module tb_iob_wishbone2iob;

  localparam int TW    = 4;
  localparam int LIMIT = (1 << TW) - 1;
`ifdef IOB_WB2IOB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cyc, stb, we, ready;
  logic [31:0] addr, wdat, rdata;
  logic [3:0]  sel;
  logic [31:0] dat_o, address, wdata_o;
  logic [3:0]  wstrb;
  logic        ack, err, valid;

  always #5 clk = ~clk;

  iob_wishbone2iob #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(TW)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_addr_i(addr),
    .wb_select_i(sel), .wb_data_i(wdat), .wb_data_o(dat_o),
    .wb_ack_o(ack), .wb_error_o(err),
    .valid_o(valid), .address_o(address), .wdata_o(wdata_o), .wstrb_o(wstrb),
    .rdata_i(rdata), .ready_i(ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_acks   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding IOb access, plus the response pulse.
  bit          m_busy, m_ack, m_err, m_we, m_abort, m_ab, m_na, m_ne;
  int          m_wait;
  logic [31:0] m_addr, m_data, m_rdata;
  logic [3:0]  m_sel;

  initial forever begin
    @(posedge clk or negedge arst_n);
    if (!arst_n) begin
      m_busy = 0; m_ack = 0; m_err = 0; m_we = 0; m_abort = 0; m_wait = 0;
      m_addr = '0; m_data = '0; m_rdata = '0; m_sel = '0;
    end else begin
      m_na = 0;
      m_ne = 0;
      if (m_busy) begin
        m_ab = m_abort || !cyc;
        if (ready) begin
          if (!m_we) m_rdata = rdata;
          m_busy = 0;
          m_na   = !m_ab;
        end else if (TO_EN && m_wait == LIMIT) begin
          m_busy = 0;
          m_ne   = !m_ab;
        end else begin
          m_wait++;
          m_abort = m_ab;
        end
      end else if (!m_ack && cyc && stb) begin
        m_busy = 1; m_wait = 0; m_abort = 0;
        m_addr = addr; m_data = wdat; m_sel = sel; m_we = we;
      end
      m_ack = m_na;
      m_err = m_ne;
    end
  end

  initial forever begin
    @(negedge clk);
    if (ack) n_acks++;
    chk("valid", valid, m_busy);
    chk("ack", ack, m_ack);
    chk("error", err, m_err);
    chk("wb_data_o", dat_o, m_rdata);
    chk("ack_err_excl", ack & err, 0);
    if (m_busy) begin
      chk("address", address, m_addr);
      chk("wdata", wdata_o, m_data);
      chk("wstrb", wstrb, m_we ? m_sel : 4'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    cyc = 1; stb = 1; we = w; addr = a; sel = s; wdat = d;
  endtask

  task automatic idle_bus();
    cyc = 0; stb = 0; we = 0;
  endtask

  bit active;
  int rpct, acks0;

  initial begin
    arst_n = 0; cyc = 0; stb = 0; we = 0; ready = 0;
    addr = 0; wdat = 0; rdata = 0; sel = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_data", dat_o, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_wstrb", wstrb, 0);
    #2 arst_n = 1;
    step();

    // Write, ready in the third REQ cycle
    start(1, 32'h100, 4'hF, 32'hDEADBEEF);
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ready = 1;
      @(negedge clk);
      chk("wr_valid", valid, 1);
      chk("wr_wstrb", wstrb, 4'hF);
      chk("wr_wdata", wdata_o, 32'hDEADBEEF);
      chk("wr_noack", ack, 0);
      step();
    end
    ready = 0; idle_bus();
    @(negedge clk);
    chk("wr_ack", ack, 1);
    chk("wr_data_kept", dat_o, 0);
    step();
    @(negedge clk);
    chk("wr_ack_once", ack, 0);

    // Read, ready in the first REQ cycle
    step();
    start(0, 32'h104, 4'h3, 32'h0);
    step();
    ready = 1; rdata = 32'h12345678;
    @(negedge clk);
    chk("rd_valid", valid, 1);
    chk("rd_wstrb", wstrb, 0);
    chk("rd_addr", address, 32'h104);
    step();
    ready = 0; rdata = 0; idle_bus();
    @(negedge clk);
    chk("rd_ack", ack, 1);
    chk("rd_data", dat_o, 32'h12345678);
    step();

    // Back-to-back reads with stb held across the ack
    acks0 = n_acks;
    start(0, 32'h200, 4'hF, 32'h0);
    step();
    ready = 1; rdata = 32'hA5A50001;
    step();
    ready = 0;
    @(negedge clk);
    chk("b2b_ack1", ack, 1);
    step();
    @(negedge clk);
    chk("b2b_gap_valid", valid, 0);
    chk("b2b_gap_ack", ack, 0);
    step();
    ready = 1; rdata = 32'h0000BEEF;
    @(negedge clk);
    chk("b2b_valid2", valid, 1);
    step();
    ready = 0; idle_bus();
    @(negedge clk);
    chk("b2b_data2", dat_o, 32'h0000BEEF);
    step(); step();
    chk("b2b_ack_count", n_acks - acks0, 2);

    // Abort: cyc drops in the first REQ cycle, ready two cycles later
    start(1, 32'h300, 4'hC, 32'h11223344);
    step();
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ready = 1;
      @(negedge clk);
      chk("ab_valid", valid, 1);
      step();
    end
    ready = 0;
    @(negedge clk);
    chk("ab_valid_drop", valid, 0);
    chk("ab_noack", ack, 0);
    chk("ab_noerr", err, 0);
    step();
    @(negedge clk);
    chk("ab_noack2", ack, 0);

`ifdef IOB_WB2IOB_TIMEOUT_EN
    // Watchdog: ready never comes
    step();
    start(0, 32'h400, 4'hF, 32'h0);
    step();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("to_valid", valid, 1);
      chk("to_noerr", err, 0);
      if (i < 15) step();
    end
    step();
    idle_bus();
    @(negedge clk);
    chk("to_valid_drop", valid, 0);
    chk("to_err", err, 1);
    step();
    ready = 1; rdata = 32'hFFFF0000;
    @(negedge clk);
    chk("to_err_once", err, 0);
    step();
    ready = 0;
    @(negedge clk);
    chk("to_late_noack", ack, 0);
    chk("to_late_data", dat_o, 32'h0000BEEF);
`endif

    // Reset in the middle of a REQ
    step();
    start(1, 32'h500, 4'hF, 32'hCAFEF00D);
    step();
    @(negedge clk);
    #2 arst_n = 0; idle_bus();
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_data", dat_o, 0);
    chk("mid_rst_addr", address, 0);
    @(negedge clk);
    #2 arst_n = 1;
    step();
    start(1, 32'h504, 4'h1, 32'h0BADC0DE);
    step();
    ready = 1;
    @(negedge clk);
    chk("post_rst_valid", valid, 1);
    chk("post_rst_wdata", wdata_o, 32'h0BADC0DE);
    chk("post_rst_wstrb", wstrb, 4'h1);
    step();
    ready = 0; idle_bus();
    @(negedge clk);
    chk("post_rst_ack", ack, 1);
    step();

    // Randomized traffic, ready density varied per segment
    active = 0;
    rpct   = 30;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(2))
          0:       rpct = 3;
          1:       rpct = 30;
          default: rpct = 80;
        endcase
      end
      step();
      ready = ($urandom_range(99) < rpct);
      rdata = $urandom;
      if (active) begin
        if (m_ack || m_err) begin
          active = 0;
          if ($urandom_range(1) == 0) begin
            start($urandom_range(1), $urandom, $urandom_range(15), $urandom);
            active = 1;
          end else begin
            idle_bus();
          end
        end else if ($urandom_range(29) == 0) begin
          idle_bus();
          active = 0;
        end
      end else if ($urandom_range(3) == 0) begin
        start($urandom_range(1), $urandom, $urandom_range(15), $urandom);
        active = 1;
      end
    end
    idle_bus();
    ready = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
